// File: rtl/mem_pkg.sv
// mem_pkg: shared memory-subsystem widths, FSM states and port-owner encoding
package mem_pkg;
    localparam int MEM_ADDR_W = 5;
    localparam int MEM_DATA_W = 32;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic {OWN_I = 1'b0, OWN_D = 1'b1} owner_t;
endpackage

// File: rtl/prio_aging_arb.sv
// prio_aging_arb: data-priority grant with an aging counter that bounds fetch starvation
module prio_aging_arb #(
    parameter int MAX_WAIT = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       arb_en,
    input  logic       i_req,
    input  logic       d_req,
    output logic       grant_i,
    output logic [3:0] wait_cnt
);
    assign grant_i = i_req && (!d_req || wait_cnt == 4'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (reset)
            wait_cnt <= '0;
        else if (arb_en && (i_req || d_req))
            wait_cnt <= grant_i ? 4'd0 :
                        (i_req && wait_cnt < 4'(MAX_WAIT)) ? wait_cnt + 4'd1 : wait_cnt;
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port memory between fetch and data requesters
module mem_port_arbiter
    import mem_pkg::*;
#(
    parameter int ADDR_W   = MEM_ADDR_W,
    parameter int DATA_W   = MEM_DATA_W,
    parameter int MAX_WAIT = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_din,
    output logic              m_rd,
    output logic              m_wr,
    input  logic [DATA_W-1:0] m_dout,
    output logic              busy
);
    state_t            state, state_nx;
    owner_t            owner;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic              arb_en, grant_i;
    logic [3:0]        wait_cnt;

    assign arb_en = state == IDLE;

    prio_aging_arb #(.MAX_WAIT(MAX_WAIT)) u_arb (
        .clk      (clk),
        .reset    (reset),
        .arb_en   (arb_en),
        .i_req    (i_req),
        .d_req    (d_req),
        .grant_i  (grant_i),
        .wait_cnt (wait_cnt)
    );

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        m_addr   = '0;
        m_din    = '0;
        m_rd     = 1'b0;
        m_wr     = 1'b0;
        state_nx = state == IDLE ? ((i_req || d_req) ? ACCESS : IDLE) :
                   state == ACCESS ? DONE : IDLE;
        m_addr   = state == ACCESS ? addr_q : '0;
        m_rd     = state == ACCESS && !we_q;
        m_wr     = state == ACCESS && we_q;
        m_din    = (state == ACCESS && we_q) ? wdata_q : '0;
        i_ack    = state == DONE && owner == OWN_I;
        d_ack    = state == DONE && owner == OWN_D;
        busy     = state != IDLE;
    end

    // Request fields are captured once at the arbitration edge so later input changes cannot leak in
    always_ff @(posedge clk) begin
        if (reset) begin
            owner   <= OWN_I;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            i_rdata <= '0;
            d_rdata <= '0;
        end else begin
            if (arb_en && (i_req || d_req)) begin
                owner   <= grant_i ? OWN_I : OWN_D;
                we_q    <= !grant_i && d_we;
                addr_q  <= grant_i ? i_addr : d_addr;
                wdata_q <= d_wdata;
            end
            if (state == ACCESS && !we_q) begin
                if (owner == OWN_I)
                    i_rdata <= m_dout;
                else
                    d_rdata <= m_dout;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed self-checking bench with a behavioural 32x32 memory
module tb_mem_port_arbiter;
    import mem_pkg::*;

    logic        clk = 0, reset = 1;
    logic        i_req = 0, d_req = 0, d_we = 0;
    logic [4:0]  i_addr = 0, d_addr = 0;
    logic [31:0] d_wdata = 0;
    logic        i_ack, d_ack, m_rd, m_wr, busy;
    logic [31:0] i_rdata, d_rdata, m_din, m_dout;
    logic [4:0]  m_addr;
    logic [31:0] mem [32];
    int tests = 0, fails = 0;

    always #5 clk = ~clk;

    mem_port_arbiter dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_addr(m_addr), .m_din(m_din), .m_rd(m_rd), .m_wr(m_wr), .m_dout(m_dout),
        .busy(busy)
    );

    assign m_dout = mem[m_addr];

    always @(posedge clk) begin
        if (reset) begin
            mem[1]  <= 32'hAAAA_0001;
            mem[2]  <= 32'hBBBB_0002;
            mem[4]  <= 32'h2943_0064;
            mem[11] <= 32'h1111_1111;
        end
        if (m_wr) mem[m_addr] <= m_din;
    end

    task automatic test_reset;
        repeat (2) @(negedge clk);
        reset = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            tests++;
            if ({i_ack, d_ack, m_rd, m_wr, busy} !== 5'b0) begin
                fails++; $display("FAIL reset_ctrl[%0d]: got %b expected 00000", c, {i_ack, d_ack, m_rd, m_wr, busy});
            end
            tests++;
            if ({i_rdata, d_rdata, m_din, m_addr} !== '0) begin
                fails++; $display("FAIL reset_data[%0d]: got %h/%h/%h/%h expected 0", c, i_rdata, d_rdata, m_din, m_addr);
            end
        end
    endtask

    task automatic test_single_fetch;
        i_req = 1; i_addr = 5'd4;
        @(negedge clk);
        tests++;
        if ({m_rd, m_wr, busy, i_ack} !== 4'b1010 || m_addr !== 5'd4) begin
            fails++; $display("FAIL fetch_access: got rd/wr/busy/ack=%b addr=%0d expected 1010 addr=4", {m_rd, m_wr, busy, i_ack}, m_addr);
        end
        @(negedge clk);
        tests++;
        if ({i_ack, d_ack, m_rd} !== 3'b100 || i_rdata !== 32'h2943_0064) begin
            fails++; $display("FAIL fetch_ack: got acks/rd=%b rdata=%h expected 100 29430064", {i_ack, d_ack, m_rd}, i_rdata);
        end
        i_req = 0;
        @(negedge clk);
        tests++;
        if ({i_ack, busy} !== 2'b00 || i_rdata !== 32'h2943_0064) begin
            fails++; $display("FAIL fetch_hold: got ack/busy=%b rdata=%h expected 00 29430064", {i_ack, busy}, i_rdata);
        end
    endtask

    task automatic test_write_read;
        d_req = 1; d_we = 1; d_addr = 5'd10; d_wdata = 32'hDEAD_BEEF;
        @(negedge clk);
        tests++;
        if ({m_wr, m_rd} !== 2'b10 || m_addr !== 5'd10 || m_din !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL write_access: got wr/rd=%b addr=%0d din=%h expected 10 10 deadbeef", {m_wr, m_rd}, m_addr, m_din);
        end
        @(negedge clk);
        tests++;
        if ({d_ack, i_ack, m_wr} !== 3'b100) begin
            fails++; $display("FAIL write_ack: got %b expected 100", {d_ack, i_ack, m_wr});
        end
        d_req = 0;
        @(negedge clk);
        tests++;
        if (mem[10] !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL write_mem: got %h expected deadbeef", mem[10]);
        end
        d_req = 1; d_we = 0; d_addr = 5'd10;
        @(negedge clk);
        tests++;
        if ({m_rd, m_wr} !== 2'b10 || m_din !== 32'h0) begin
            fails++; $display("FAIL read_access: got rd/wr=%b din=%h expected 10 0", {m_rd, m_wr}, m_din);
        end
        @(negedge clk);
        tests++;
        if (d_ack !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL read_ack: got ack=%b rdata=%h expected 1 deadbeef", d_ack, d_rdata);
        end
        d_req = 0;
        @(negedge clk);
    endtask

    task automatic test_late_change;
        d_req = 1; d_we = 0; d_addr = 5'd10;
        @(negedge clk);
        d_addr = 5'd11;
        #1;
        tests++;
        if (m_addr !== 5'd10 || m_rd !== 1'b1) begin
            fails++; $display("FAIL late_addr: got addr=%0d rd=%b expected 10 1", m_addr, m_rd);
        end
        @(negedge clk);
        tests++;
        if (d_ack !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL late_data: got ack=%b rdata=%h expected 1 deadbeef", d_ack, d_rdata);
        end
        d_req = 0;
        @(negedge clk);
    endtask

    task automatic test_contention;
        logic [7:0] grants = '0;
        logic bad_cnt = 0, bad_strobe = 0;
        int gap;
        i_req = 1; i_addr = 5'd1; d_req = 1; d_we = 0; d_addr = 5'd2;
        for (int t = 0; t < 8; t++) begin
            gap = 0;
            do begin
                @(negedge clk);
                gap++;
                if (dut.u_arb.wait_cnt > 4'd3) bad_cnt = 1;
                if (m_rd && m_wr) bad_strobe = 1;
            end while (!(i_ack || d_ack) && gap < 6);
            tests++;
            if (gap != (t == 0 ? 2 : 3)) begin
                fails++; $display("FAIL contention_gap[%0d]: got %0d expected %0d", t, gap, t == 0 ? 2 : 3);
            end
            tests++;
            if (i_ack ? (i_rdata !== 32'hAAAA_0001) : (d_rdata !== 32'hBBBB_0002)) begin
                fails++; $display("FAIL contention_data[%0d]: got i=%h d=%h", t, i_rdata, d_rdata);
            end
            grants[t] = i_ack;
        end
        i_req = 0; d_req = 0;
        @(negedge clk);
        tests++;
        if (grants !== 8'h88) begin
            fails++; $display("FAIL contention_order: got %b expected 10001000 (bit0 first, 1=fetch)", grants);
        end
        tests++;
        if (bad_cnt !== 1'b0) begin
            fails++; $display("FAIL wait_cnt_bound: got exceeded expected <=3");
        end
        tests++;
        if (bad_strobe !== 1'b0) begin
            fails++; $display("FAIL strobe_excl: got rd&wr high expected never");
        end
    endtask

    task automatic test_reset_mid;
        d_req = 1; d_we = 0; d_addr = 5'd10;
        repeat (2) @(negedge clk);
        tests++;
        if (d_ack !== 1'b1 || d_rdata !== 32'hDEAD_BEEF) begin
            fails++; $display("FAIL mid_pre: got ack=%b rdata=%h expected 1 deadbeef", d_ack, d_rdata);
        end
        reset = 1; d_req = 0;
        @(negedge clk);
        tests++;
        if ({d_ack, i_ack, busy} !== 3'b000 || d_rdata !== 32'h0 || dut.state !== IDLE) begin
            fails++; $display("FAIL mid_reset: got ack/busy=%b rdata=%h state=%0d expected 000 0 0", {d_ack, i_ack, busy}, d_rdata, dut.state);
        end
        reset = 0; i_req = 1; i_addr = 5'd4;
        @(negedge clk);
        tests++;
        if (m_rd !== 1'b1 || m_addr !== 5'd4) begin
            fails++; $display("FAIL mid_fetch_access: got rd=%b addr=%0d expected 1 4", m_rd, m_addr);
        end
        @(negedge clk);
        tests++;
        if (i_ack !== 1'b1 || i_rdata !== 32'h2943_0064) begin
            fails++; $display("FAIL mid_fetch_ack: got ack=%b rdata=%h expected 1 29430064", i_ack, i_rdata);
        end
        i_req = 0;
        @(negedge clk);
        tests++;
        if (busy !== 1'b0 || i_ack !== 1'b0) begin
            fails++; $display("FAIL mid_fetch_idle: got busy=%b ack=%b expected 0 0", busy, i_ack);
        end
    endtask

    initial begin
        test_reset;
        test_single_fetch;
        test_write_read;
        test_late_change;
        test_contention;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer that shares one single-port 32×32-bit memory between the instruction-fetch requester (read-only) and the data-access requester (read/write). It sits between the pipeline's IF and MEM stages and the memory array, and owns the array's addr/d_in/rd/wr controls. Data access has fixed priority, with an aging counter that bounds fetch starvation. Each request completes in a fixed three-cycle transaction.

## Interface
- `ADDR_W`, default 5: memory word-address width (32 words).
- `DATA_W`, default 32: data width.
- `MAX_WAIT`, default 3: consecutive lost arbitrations after which fetch wins; range 1–15.

Ports:
- `clk`  in  1: single clock, rising edge.
- `reset`  in  1: synchronous, active-high.
- `i_req`  in  1: fetch request, level, held until `i_ack`.
- `i_addr`  in  ADDR_W: fetch address.
- `i_ack`  out  1: one-cycle pulse, `i_rdata` valid.
- `i_rdata`  out  DATA_W: fetch read data, held until next fetch ack.
- `d_req`  in  1: data request, level, held until `d_ack`.
- `d_we`  in  1: 1 = write, 0 = read.
- `d_addr`  in  ADDR_W: data address.
- `d_wdata`  in  DATA_W: write data.
- `d_ack`  out  1: one-cycle pulse; for reads, `d_rdata` valid.
- `d_rdata`  out  DATA_W: data read result, held until next data read ack.
- `m_addr`  out  ADDR_W: memory address.
- `m_din`  out  DATA_W: memory write data.
- `m_rd`  out  1: memory read strobe.
- `m_wr`  out  1: memory write strobe.
- `m_dout`  in  DATA_W: memory read data, combinational from `m_addr`/`m_rd`.
- `busy`  out  1: high in ACCESS and DONE.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- **IDLE.** If any request is high at the edge, arbitrate, latch the winner's addr/we/wdata into registers, set the owner flag, and go to ACCESS. Otherwise stay in IDLE.
- **Arbitration:**
  - Data wins by default.
  - Fetch wins if only `i_req` is high, or if `wait_cnt == MAX_WAIT`.
- **Aging counter `wait_cnt`** (4 bits):
  - Increments when both requests are high and data wins.
  - Clears when fetch wins.
  - Saturates at MAX_WAIT.
- **ACCESS.** `m_addr`/`m_din`/`m_rd`/`m_wr` are driven from registers.
  - Fetch: `m_rd=1`.
  - Data read: `m_rd=1`.
  - Data write: `m_wr=1`, `m_din=d_wdata` as latched.
  - At the edge, for a read, capture `m_dout` into the owner's rdata register, then go to DONE.
- **DONE.** Owner's ack=1, memory strobes 0, no arbitration. Always go to IDLE.
- **Request lines.** A requester may drop or keep its req during DONE. A req still high in IDLE is treated as a new request.
- **Ignored inputs.** Input changes after the latch edge do not affect the transaction in flight.
- **Memory strobes.** `m_rd` and `m_wr` are never high together and are high only in ACCESS.

## Timing
- **Reset values:** state=IDLE, `i_ack=d_ack=0`, `i_rdata=d_rdata=0`, `m_addr=0`, `m_din=0`, `m_rd=m_wr=0`, `busy=0`, `wait_cnt=0`.
- **Latency.** With req high at edge k:
  - ACCESS in cycle k+1;
  - ack in cycle k+2;
  - next arbitration at edge k+3.
- **Throughput:** one transaction per 3 cycles.
- **Simultaneous requests:** only one is granted per arbitration. The loser stays pending and is arbitrated at the next IDLE edge.
- **Reset mid-operation:**
  - An ACCESS strobe visible in the reset cycle completes at the memory, since the memory is combinational.
  - At the reset edge the FSM returns to IDLE.
  - No ack is issued for the aborted transaction.
  - rdata registers are cleared.
- **Address wrap:** none. Addresses are used as-is, modulo 2^ADDR_W.

## Structure
- Shared package `mem_pkg`:
  - `ADDR_W` and `DATA_W` defaults;
  - state enum (IDLE/ACCESS/DONE);
  - owner encoding (OWN_I=0, OWN_D=1).
- The package is shared with the memory and pipeline modules.
- One natural sub-module, `prio_aging_arb`: combinational grant from `i_req`, `d_req`, `wait_cnt`, plus the `wait_cnt` register.
- FSM, latches and rdata registers live in the top.

## Test plan
- **Reset:** hold `reset` 2 cycles, then release with no requests → all outputs 0, `busy=0` indefinitely.
- **Single fetch:** `i_req=1`, `i_addr=4`, memory word 4 = 0x2943_0064 → `m_rd=1` with `m_addr=4` in k+1; `i_ack=1` with `i_rdata=0x2943_0064` in k+2; `d_ack` stays 0.
- **Data write then read:**
  - Write `d_addr=10`, `d_wdata=0xDEAD_BEEF` → `m_wr=1` in ACCESS, `d_ack` in k+2.
  - Read addr 10 → `d_rdata=0xDEAD_BEEF`.
- **Contention/aging (MAX_WAIT=3):** `i_req` and `d_req` held high continuously; each requester keeps req high after its ack → grant order D, D, D, I, D, D, D, I; `wait_cnt` never exceeds 3.
- **Reset mid-transaction:** assert `reset` during DONE of a data read → `d_ack` low from the next cycle, `d_rdata=0`, state IDLE; a subsequent fetch completes normally in 3 cycles.
- **Late input change:** change `d_addr` from 10 to 11 in the ACCESS cycle → the memory still sees `m_addr=10`, and the result is from address 10.
